// File: rtl/axi4lite_slave_pkg.sv
// Purpose : shared constants and FSM state types for the AXI4-Lite register slave.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package axi4lite_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int NUM_REGS    = 16;
  localparam int REG_COUNTER = 0;
  localparam int IDX_W       = $clog2(NUM_REGS);

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

endpackage

// File: rtl/axi4lite_slave_regfile.sv
// Purpose : 16-word register storage; word 0 is a count of successful writes.
// Latency : write takes effect on the edge wr_en is sampled; read port is combinational.
// Backpr. : none, the write port is always accepted.
// Ports   : clk/rst_n; wr_en, wr_idx, wr_data write port; rd_idx -> rd_data read port;
//           count mirrors word 0.
module axi4lite_slave_regfile
  import axi4lite_slave_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [DW-1:0]    wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [DW-1:0]    rd_data,
  output logic [DW-1:0]    count
);

  logic [DW-1:0] mem [NUM_REGS];

  // Word 0 doubles as the counter, so its reset value of 2*0 = 0 is the
  // counter's reset value too. A write aimed at word 0 is rejected: nothing
  // is stored and the count does not move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= DW'(2 * i);
      end
    end else if (wr_en && (wr_idx != IDX_W'(REG_COUNTER))) begin
      mem[wr_idx]      <= wr_data;
      mem[REG_COUNTER] <= mem[REG_COUNTER] + DW'(1);
    end
  end

  assign rd_data = mem[rd_idx];
  assign count   = mem[REG_COUNTER];

endmodule

// File: rtl/axi4lite_slave_regs.sv
// Purpose : AXI4-Lite slave front end for a 16-word register file with write counter.
// Latency : write commits and raises s_bvalid one edge after the later of AW/W; read data valid one edge after AR.
// Backpr. : s_bready low holds WR_RESP and blocks AW/W; s_rready low holds RD_RESP and blocks AR.
// Ports   : s_aclk/s_aresetn; AW, W, B, AR, R AXI4-Lite channels (prot ignored, no strobes);
//           wr_count mirrors register 0.
module axi4lite_slave_regs
  import axi4lite_slave_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                          s_aclk,
  input  logic                          s_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_awaddr,
  input  logic [2:0]                    s_awprot,
  input  logic                          s_awvalid,
  output logic                          s_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] s_wdata,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  output logic [1:0]                    s_bresp,
  output logic                          s_bvalid,
  input  logic                          s_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_araddr,
  input  logic [2:0]                    s_arprot,
  input  logic                          s_arvalid,
  output logic                          s_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rvalid,
  input  logic                          s_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] wr_count
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

  // Keeps the ready outputs low while in reset and for the first edge after it.
  logic rdy_q;

  logic             aw_held;
  logic             w_held;
  logic [IDX_W-1:0] aw_idx_q;
  logic [DW-1:0]    wdata_q;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic          wr_commit;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [DW-1:0] rd_word;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s_awprot, s_arprot, s_awaddr[1:0], s_araddr[1:0]};

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid  & s_wready;
  assign b_hs  = s_bvalid  & s_bready;
  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid  & s_rready;

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) rdy_q <= 1'b0;
    else            rdy_q <= 1'b1;
  end

  // ---------------- write FSM ----------------
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) wr_state <= WR_IDLE;
    else            wr_state <= wr_next;
  end

  always_comb begin
    wr_next   = wr_state;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    wr_commit = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        s_awready = rdy_q & ~aw_held;
        s_wready  = rdy_q & ~w_held;
        if (aw_held && w_held) begin
          wr_commit = 1'b1;
          wr_next   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_bvalid && s_bready) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  // AW and W land in their own holding registers in whichever order they
  // arrive; the commit waits until both are present.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
    end else if (b_hs) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= s_awaddr[5:2];
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_wdata;
      end
    end
  end

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      s_bvalid <= 1'b0;
      s_bresp  <= RESP_OKAY;
    end else if (wr_commit) begin
      s_bvalid <= 1'b1;
      s_bresp  <= (aw_idx_q == IDX_W'(REG_COUNTER)) ? RESP_SLVERR : RESP_OKAY;
    end else if (b_hs) begin
      s_bvalid <= 1'b0;
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) rd_state <= RD_IDLE;
    else            rd_state <= rd_next;
  end

  always_comb begin
    rd_next   = rd_state;
    s_arready = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        s_arready = rdy_q;
        if (rdy_q && s_arvalid) rd_next = RD_RESP;
      end
      RD_RESP: begin
        if (s_rvalid && s_rready) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  // The storage is sampled on the AR edge before any same-edge commit lands,
  // so a colliding read returns the pre-write value.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_rvalid <= 1'b1;
      s_rdata  <= rd_word;
      s_rresp  <= RESP_OKAY;
    end else if (r_hs) begin
      s_rvalid <= 1'b0;
    end
  end

  axi4lite_slave_regfile #(
    .DW(DW)
  ) u_regfile (
    .clk     (s_aclk),
    .rst_n   (s_aresetn),
    .wr_en   (wr_commit),
    .wr_idx  (aw_idx_q),
    .wr_data (wdata_q),
    .rd_idx  (s_araddr[5:2]),
    .rd_data (rd_word),
    .count   (wr_count)
  );

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
module tb_axi4lite_slave_regs;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        s_aclk = 1'b0;
  logic        s_aresetn;
  logic [5:0]  s_awaddr;
  logic [2:0]  s_awprot;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [5:0]  s_araddr;
  logic [2:0]  s_arprot;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] wr_count;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  rd_exp_t    q_r[$];
  logic [1:0] q_b[$];

  int n_pass  = 0;
  int n_total = 0;

  always #5 s_aclk = ~s_aclk;

  axi4lite_slave_regs dut (
    .s_aclk    (s_aclk),
    .s_aresetn (s_aresetn),
    .s_awaddr  (s_awaddr),
    .s_awprot  (s_awprot),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arprot  (s_arprot),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .wr_count  (wr_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge s_aclk);
      #1;
    end
  endtask

  task automatic send_aw(input logic [5:0] a);
    bit ok = 0;
    s_awaddr  = a;
    s_awvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge s_aclk);
      if (s_awready) ok = 1;
    end
    chk("aw_handshake", 32'(ok), 32'd1);
    @(posedge s_aclk);
    #1;
    s_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d);
    bit ok = 0;
    s_wdata  = d;
    s_wvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge s_aclk);
      if (s_wready) ok = 1;
    end
    chk("w_handshake", 32'(ok), 32'd1);
    @(posedge s_aclk);
    #1;
    s_wvalid = 1'b0;
  endtask

  // Issues AW and W (in the chosen order, gap idle cycles apart) and checks the
  // one-edge commit latency. Returns at the negedge where s_bvalid is first high.
  task automatic write_req(input logic [5:0] a, input logic [31:0] d, input bit w_first,
                           input int gap, input logic [1:0] exp);
    q_b.push_back(exp);
    if (w_first) begin
      send_w(d);
      idle(gap);
      send_aw(a);
    end else begin
      send_aw(a);
      idle(gap);
      send_w(d);
    end
    @(negedge s_aclk);
    chk("bvalid_before_commit", 32'(s_bvalid), 32'd0);
    @(negedge s_aclk);
    chk("bvalid_after_commit", 32'(s_bvalid), 32'd1);
  endtask

  task automatic wait_b();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (s_bvalid && s_bready) ok = 1;
      else @(negedge s_aclk);
    end
    chk("b_handshake", 32'(ok), 32'd1);
    @(posedge s_aclk);
    #1;
  endtask

  task automatic do_read(input logic [5:0] a, input logic [31:0] exp);
    bit ok = 0;
    q_r.push_back('{data: exp, resp: OKAY});
    s_araddr  = a;
    s_arvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge s_aclk);
      if (s_arready) ok = 1;
    end
    chk("ar_handshake", 32'(ok), 32'd1);
    @(posedge s_aclk);
    #1;
    s_arvalid = 1'b0;
    @(negedge s_aclk);
    chk("rvalid_latency", 32'(s_rvalid), 32'd1);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (s_rvalid && s_rready) ok = 1;
      else @(negedge s_aclk);
    end
    chk("r_handshake", 32'(ok), 32'd1);
    @(posedge s_aclk);
    #1;
  endtask

  // Scoreboard monitor: compares every B and R beat as the DUT hands it over.
  initial begin
    logic [1:0] eb;
    rd_exp_t    er;
    forever begin
      @(negedge s_aclk);
      if (s_aresetn) begin
        if (s_bvalid && s_bready) begin
          if (q_b.size() == 0) begin
            n_total++;
            $display("FAIL b_unexpected: got bresp 0x%0h with no write outstanding", s_bresp);
          end else begin
            eb = q_b.pop_front();
            chk("bresp", 32'(s_bresp), 32'(eb));
          end
        end
        if (s_rvalid && s_rready) begin
          if (q_r.size() == 0) begin
            n_total++;
            $display("FAIL r_unexpected: got rdata 0x%08h with no read outstanding", s_rdata);
          end else begin
            er = q_r.pop_front();
            chk("rdata", s_rdata, er.data);
            chk("rresp", 32'(s_rresp), 32'(er.resp));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    s_aresetn = 1'b0;
    s_awaddr  = '0;
    s_awprot  = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b1;
    s_araddr  = '0;
    s_arprot  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b1;

    // Reset state
    repeat (3) @(posedge s_aclk);
    @(negedge s_aclk);
    chk("rst_awready", 32'(s_awready), 32'd0);
    chk("rst_wready",  32'(s_wready),  32'd0);
    chk("rst_arready", 32'(s_arready), 32'd0);
    chk("rst_bvalid",  32'(s_bvalid),  32'd0);
    chk("rst_rvalid",  32'(s_rvalid),  32'd0);
    chk("rst_rdata",   s_rdata,        32'd0);
    chk("rst_wr_count", wr_count,      32'd0);
    @(posedge s_aclk);
    #1;
    s_aresetn = 1'b1;
    @(negedge s_aclk);
    chk("awready_before_first_edge", 32'(s_awready), 32'd0);
    @(negedge s_aclk);
    chk("awready_after_first_edge", 32'(s_awready), 32'd1);
    chk("arready_after_first_edge", 32'(s_arready), 32'd1);
    @(posedge s_aclk);
    #1;

    // Reset value of a plain word
    do_read(6'h14, 32'd10);

    // AW first, W three cycles later
    write_req(6'h0C, 32'hDEADBEEF, 1'b0, 3, OKAY);
    wait_b();
    do_read(6'h0C, 32'hDEADBEEF);
    chk("wr_count_after_1", wr_count, 32'd1);

    // Word 0 is read-only
    write_req(6'h00, 32'h12345678, 1'b0, 0, SLVERR);
    wait_b();
    do_read(6'h00, 32'd1);
    chk("wr_count_after_slverr", wr_count, 32'd1);

    // W first; byte offset bits ignored on the read
    write_req(6'h20, 32'h0000A5A5, 1'b1, 2, OKAY);
    wait_b();
    do_read(6'h23, 32'h0000A5A5);
    do_read(6'h00, 32'd2);

    // B backpressure with an independent read in the middle
    s_bready = 1'b0;
    write_req(6'h04, 32'h00000011, 1'b0, 0, OKAY);
    @(posedge s_aclk);
    #1;
    do_read(6'h30, 32'd24);
    for (int i = 0; i < 5; i++) begin
      @(negedge s_aclk);
      chk("bp_bvalid",  32'(s_bvalid),  32'd1);
      chk("bp_awready", 32'(s_awready), 32'd0);
    end
    @(posedge s_aclk);
    #1;
    s_bready = 1'b1;
    wait_b();
    chk("wr_count_after_bp", wr_count, 32'd3);
    do_read(6'h04, 32'h00000011);

    // Read and write of word 7 on the same edge
    s_awaddr  = 6'h1C;
    s_awvalid = 1'b1;
    s_wdata   = 32'hCAFE0007;
    s_wvalid  = 1'b1;
    @(negedge s_aclk);
    chk("coll_awready", 32'(s_awready), 32'd1);
    chk("coll_wready",  32'(s_wready),  32'd1);
    @(posedge s_aclk);
    #1;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    q_b.push_back(OKAY);
    q_r.push_back('{data: 32'd14, resp: OKAY});
    s_araddr  = 6'h1C;
    s_arvalid = 1'b1;
    @(negedge s_aclk);
    chk("coll_arready", 32'(s_arready), 32'd1);
    @(posedge s_aclk);
    #1;
    s_arvalid = 1'b0;
    @(negedge s_aclk);
    chk("coll_rvalid", 32'(s_rvalid), 32'd1);
    chk("coll_bvalid", 32'(s_bvalid), 32'd1);
    wait_b();
    do_read(6'h1C, 32'hCAFE0007);
    chk("wr_count_after_coll", wr_count, 32'd4);

    // Reset with a response pending
    s_bready = 1'b0;
    write_req(6'h08, 32'h00000099, 1'b0, 0, OKAY);
    void'(q_b.pop_back());
    @(posedge s_aclk);
    #1;
    s_aresetn = 1'b0;
    #1;
    chk("midrst_bvalid",   32'(s_bvalid),  32'd0);
    chk("midrst_awready",  32'(s_awready), 32'd0);
    chk("midrst_wr_count", wr_count,       32'd0);
    @(posedge s_aclk);
    #1;
    s_aresetn = 1'b1;
    s_bready  = 1'b1;
    idle(1);
    do_read(6'h0C, 32'd6);
    do_read(6'h1C, 32'd14);
    do_read(6'h08, 32'd4);
    do_read(6'h00, 32'd0);
    write_req(6'h3C, 32'h00000001, 1'b1, 0, OKAY);
    wait_b();
    do_read(6'h3C, 32'h00000001);
    chk("wr_count_after_reset_write", wr_count, 32'd1);

    idle(3);
    chk("b_queue_drained", 32'(q_b.size()), 32'd0);
    chk("r_queue_drained", 32'(q_r.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi4lite_slave_regs.md
# axi4lite_slave_regs

AXI4-Lite slave with a 16-word register file; the responder end of the bus driven by the AXI4-Lite master block. It accepts single-beat writes and reads from the master, stores 32-bit words, and returns OKAY/SLVERR responses. It also exposes a read-only count of completed writes so the bench and the master side can check bus activity.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address width; bits [5:2] select one of 16 words, bits [1:0] are ignored.
- s_aclk  in  1  clock; every register updates on the rising edge.
- s_aresetn  in  1  reset, asynchronous and active-low. One clock domain; reset polarity and synchronicity are fixed.
- s_awaddr  in  ADDR  write address. s_awprot  in  3  ignored. s_awvalid  in  1. s_awready  out  1.
- s_wdata  in  DATA  write data. There is no strobe: every write is a full word. s_wvalid  in  1. s_wready  out  1.
- s_bresp  out  2  write response. s_bvalid  out  1. s_bready  in  1.
- s_araddr  in  ADDR  read address. s_arprot  in  3  ignored. s_arvalid  in  1. s_arready  out  1.
- s_rdata  out  DATA  read data. s_rresp  out  2  read response. s_rvalid  out  1. s_rready  in  1.
- wr_count  out  DATA  mirror of register 0, the completed-write counter.

## Operation
- Register map: word 0 is the read-only write counter. Words 1..15 are read/write; the reset value of word i is 2*i.
- **Write FSM** has two states, WR_IDLE and WR_RESP.
  - WR_IDLE: s_awready = ~aw_held and s_wready = ~w_held.
  - Address and data are accepted independently and in either order. Each is latched into its holding register on its own handshake.
  - When aw_held and w_held are both set, the next edge commits the write, sets s_bvalid and moves to WR_RESP.
  - Commit to word 0: no storage change, s_bresp = SLVERR (2'b10).
  - Commit to words 1..15: the word is written, s_bresp = OKAY (2'b00), and the counter increments, wrapping from 2^32-1 to 0.
  - WR_RESP: s_awready = s_wready = 0. On s_bvalid & s_bready, go to WR_IDLE and clear both held flags.
- **Read FSM** has two states, RD_IDLE and RD_RESP.
  - RD_IDLE: s_arready = 1. An AR handshake registers s_rdata = word[araddr[5:2]] and s_rresp = OKAY, sets s_rvalid and moves to RD_RESP.
  - RD_RESP: s_arready = 0. s_rdata and s_rresp stay stable until s_rvalid & s_rready, then go to RD_IDLE.
- The read and write channels are fully independent.
- Simultaneous read and write commit to the same word on the same edge: the read returns the old value.
- s_bvalid and s_rvalid never depend combinationally on s_bready or s_rready.

## Timing
- Reset values:
  - s_awready = s_wready = s_arready = 0 while s_aresetn is low; they rise on the first edge after release.
  - s_bvalid = s_rvalid = 0; s_bresp = s_rresp = 0; s_rdata = 0.
  - Words reset to 2*i; wr_count = 0.
- Write latency: the last of the AW/W handshakes happens at edge N. The commit and s_bvalid both occur at edge N+1.
- Minimum write period is 3 cycles when s_bready is held high.
- Read latency: AR handshake at edge N, then s_rvalid is high after edge N. Minimum read period is 2 cycles.
- Backpressure: with s_bready low, WR_RESP holds indefinitely and no further AW or W is accepted. With s_rready low, no further AR is accepted.
- Reset asserted mid-transaction: all state clears immediately. The pending response is dropped and a held address or data is discarded.

## Structure
- Package axi4lite_slave_pkg holds:
  - the RESP_OKAY and RESP_SLVERR constants;
  - NUM_REGS = 16 and REG_COUNTER = 0;
  - the write and read FSM state enums.
- Sub-module axi4lite_slave_regfile holds the 16-word storage, the reset initialisation and the write counter. It has one write port (en, idx, data) and one combinational read port.
- The top level contains the holding registers, both FSMs and the response registers.

## Test plan
- Reset, then read word 5 -> s_rdata = 10, OKAY, s_rvalid one cycle after the AR handshake.
- AW before W: write 0xDEADBEEF to byte address 0x0C, with W arriving 3 cycles after AW -> OKAY; word 3 reads back 0xDEADBEEF; wr_count = 1.
- Write to word 0 -> SLVERR; a read of word 0 still returns the count of earlier successful writes.
- Hold s_bready low for 5 cycles after a write -> s_bvalid stays high and s_awready stays low. Issue a read during this time -> it completes normally.
- Read and write to word 7 committing on the same edge -> the read returns 14 and a later read returns the new value.
- Assert s_aresetn while s_bvalid is high -> s_bvalid drops immediately, word values return to 2*i, wr_count = 0.
